// File: rtl/alu_issue_seq.sv
// Issue sequencer between decode and the register file / ALU. It takes one instruction per
// handshake, reads its operands, runs the ALU, then writes rd back or reports the branch outcome.
module alu_issue_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_ovf,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              br_valid,
    output logic              br_taken,
    output logic              ovf_trap,
    output logic              illegal_op
);

    localparam int unsigned OPC_W = 4;
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_BEQ = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(7);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

    state_t            state, state_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] raddr_a_d, raddr_b_d, waddr_d;
    logic [DATA_W-1:0] alu_a_d, alu_b_d, wdata_d;
    logic [2:0]        alu_sel_d;
    logic              ready_d, we_d, br_valid_d, br_taken_d, ovf_d, ill_d;

    // Next state plus next value of every registered output; result pulses are computed one
    // cycle early so that they appear registered during DONE.
    always_comb begin
        state_d    = state;
        opcode_d   = opcode_q;
        rd_d       = rd_q;
        raddr_a_d  = rf_raddr_a;
        raddr_b_d  = rf_raddr_b;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        alu_sel_d  = alu_sel;
        waddr_d    = rf_waddr;
        wdata_d    = rf_wdata;
        we_d       = 1'b0;
        br_valid_d = 1'b0;
        br_taken_d = 1'b0;
        ovf_d      = 1'b0;
        ill_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    opcode_d = opcode;
                    rd_d     = rd;
                    if (opcode[3]) begin
                        state_d = S_DONE;
                        ill_d   = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        raddr_a_d = rs;
                        raddr_b_d = rt;
                        alu_sel_d = opcode[2:0];
                    end
                end
            end
            S_READ: begin
                alu_a_d = rf_rdata_a;
                alu_b_d = rf_rdata_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_DONE;
                if (opcode_q == OP_BEQ || opcode_q == OP_BNE) begin
                    br_valid_d = 1'b1;
                    br_taken_d = alu_zero;
                end else if (opcode_q == OP_ADD && alu_ovf) begin
                    ovf_d = 1'b1;
                end else if (rd_q != '0) begin
                    we_d    = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = alu_f;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset drops any in-flight instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opcode_q    <= '0;
            rd_q        <= '0;
            instr_ready <= 1'b1;
            rf_raddr_a  <= '0;
            rf_raddr_b  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            br_valid    <= 1'b0;
            br_taken    <= 1'b0;
            ovf_trap    <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            state       <= state_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            instr_ready <= ready_d;
            rf_raddr_a  <= raddr_a_d;
            rf_raddr_b  <= raddr_b_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_sel     <= alu_sel_d;
            rf_we       <= we_d;
            rf_waddr    <= waddr_d;
            rf_wdata    <= wdata_d;
            br_valid    <= br_valid_d;
            br_taken    <= br_taken_d;
            ovf_trap    <= ovf_d;
            illegal_op  <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural register file and ALU around the DUT.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [3:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [31:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_f, rf_wdata;
    logic [2:0]  alu_sel;
    logic        alu_ovf, alu_zero, rf_we, br_valid, br_taken, ovf_trap, illegal_op;

    logic [31:0] regs [32];
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .br_valid(br_valid), .br_taken(br_taken),
        .ovf_trap(ovf_trap), .illegal_op(illegal_op)
    );

    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];

    // Reference 32-bit ALU
    always_comb begin
        alu_f    = '0;
        alu_ovf  = 1'b0;
        alu_zero = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd1: alu_f = ~alu_a;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = {31'b0, $signed(alu_a) < $signed(alu_b)};
            3'd5: alu_f = alu_a << alu_b[4:0];
            3'd6: alu_zero = (alu_a == alu_b);
            default: alu_zero = (alu_a != alu_b);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 none, 1 write-back, 2 branch, 3 ovf trap, 4 illegal
    task automatic run(input string tag, input logic [3:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input int kind,
                       input logic [31:0] exp_data, input logic exp_taken);
        int n = 0;
        int idx;
        logic [3:0] expv;
        while (!instr_ready && n < 10) begin
            step();
            n++;
        end
        check({tag, "/ready_wait"}, 32'(instr_ready), 32'd1);
        opcode = op; rs = a; rt = b; rd = d; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        idx = op[3] ? 0 : 2;
        case (kind)
            1: expv = 4'b1000;
            2: expv = 4'b0100;
            3: expv = 4'b0010;
            4: expv = 4'b0001;
            default: expv = 4'b0000;
        endcase
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s/pulses@%0d", tag, i), 32'({rf_we, br_valid, ovf_trap, illegal_op}),
                  (i == idx) ? 32'(expv) : 32'd0);
            if (i == 1 && !op[3]) check({tag, "/alu_sel"}, 32'(alu_sel), 32'(op[2:0]));
            if (i == idx) begin
                check({tag, "/ready_done"}, 32'(instr_ready), 32'd0);
                if (kind == 1) begin
                    check({tag, "/waddr"}, 32'(rf_waddr), 32'(d));
                    check({tag, "/wdata"}, rf_wdata, exp_data);
                end
                if (kind == 2) check({tag, "/taken"}, 32'(br_taken), 32'(exp_taken));
            end
            if (i == idx + 1) check({tag, "/ready_after"}, 32'(instr_ready), 32'd1);
            if (i < 4) step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; rs = '0; rt = '0; rd = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset/ready", 32'(instr_ready), 32'd1);
        check("reset/pulses", 32'({rf_we, br_valid, br_taken, ovf_trap, illegal_op}), 32'd0);
        check("reset/alu_a", alu_a, 32'd0);
        check("reset/wdata", rf_wdata, 32'd0);

        regs[1] = 32'd5; regs[2] = 32'd7;
        run("add", 4'b0000, 5'd1, 5'd2, 5'd3, 1, 32'd12, 1'b0);
        regs[1] = 32'h7FFF_FFFF; regs[2] = 32'd1;
        run("add_ovf", 4'b0000, 5'd1, 5'd2, 5'd4, 3, 32'd0, 1'b0);
        regs[1] = 32'd9; regs[2] = 32'd9;
        run("beq", 4'b0110, 5'd1, 5'd2, 5'd0, 2, 32'd0, 1'b1);
        run("bne", 4'b0111, 5'd1, 5'd2, 5'd0, 2, 32'd0, 1'b0);
        regs[1] = 32'hFFFF_FFFD; regs[2] = 32'd2;
        run("slt", 4'b0100, 5'd1, 5'd2, 5'd5, 1, 32'd1, 1'b0);
        run("sll_r0", 4'b0101, 5'd2, 5'd1, 5'd0, 0, 32'd0, 1'b0);
        regs[10] = 32'hF0F0_1234; regs[11] = 32'h0FF0_FF00; regs[12] = 32'd3; regs[13] = 32'd4;
        run("and", 4'b0010, 5'd10, 5'd11, 5'd20, 1, 32'h00F0_1200, 1'b0);
        run("or", 4'b0011, 5'd10, 5'd11, 5'd21, 1, 32'hFFF0_FF34, 1'b0);
        run("not", 4'b0001, 5'd10, 5'd11, 5'd22, 1, 32'h0F0F_EDCB, 1'b0);
        run("sll", 4'b0101, 5'd12, 5'd13, 5'd7, 1, 32'h0000_0030, 1'b0);
        run("illegal", 4'b1010, 5'd1, 5'd2, 5'd3, 4, 32'd0, 1'b0);

        // Illegal opcode with instr_valid held high: re-accept only once back in IDLE
        opcode = 4'b1111; instr_valid = 1'b1;
        step();
        check("ill_hold/pulse0", 32'({illegal_op, instr_ready}), 32'b10);
        step();
        check("ill_hold/pulse1", 32'({illegal_op, instr_ready}), 32'b01);
        step();
        check("ill_hold/pulse2", 32'({illegal_op, instr_ready}), 32'b10);
        instr_valid = 1'b0;
        step();
        check("ill_hold/pulse3", 32'({illegal_op, instr_ready}), 32'b01);

        // Reset asserted during EXEC of an ADD
        regs[1] = 32'd5; regs[2] = 32'd7;
        opcode = 4'b0000; rs = 5'd1; rt = 5'd2; rd = 5'd6; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        check("rst_mid/exec_we", 32'(rf_we), 32'd0);
        rst_n = 1'b0;
        step();
        check("rst_mid/pulses", 32'({rf_we, br_valid, br_taken, ovf_trap, illegal_op}), 32'd0);
        check("rst_mid/alu_a", alu_a, 32'd0);
        check("rst_mid/alu_b", alu_b, 32'd0);
        check("rst_mid/wdata", rf_wdata, 32'd0);
        check("rst_mid/addrs", 32'({alu_sel, rf_raddr_a, rf_raddr_b, rf_waddr}), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_mid/ready", 32'(instr_ready), 32'd1);
        check("rst_mid/we_after", 32'(rf_we), 32'd0);
        step();
        check("rst_mid/we_after2", 32'(rf_we), 32'd0);
        run("add_again", 4'b0000, 5'd1, 5'd2, 5'd6, 1, 32'd12, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
